cacheline_adapter: RTL and testbench
====================================

# cacheline_adapter

Responder on the cache's physical-memory side: accepts 256-bit line read/write requests from the lowest-level cache (its `pmem_*` port) and executes each as a 4-beat, 64-bit burst on the physical memory bus. It sits between the L2 cache and main memory. It buffers one line, sequences the burst beats, and returns a single-cycle line response.

## Interface
- Parameters: none. Widths are fixed: 32-bit address, 256-bit line, 64-bit beat, 4 beats per line.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `line_read`  in  1  cache requests a line read; held until `line_resp`.
- `line_write`  in  1  cache requests a line write; held until `line_resp`.
- `line_address`  in  32  line address; bits [4:0] are ignored.
- `line_wdata`  in  256  line to write; sampled at acceptance.
- `line_rdata`  out  256  assembled read line; valid when `line_resp` is high.
- `line_resp`  out  1  one-cycle completion pulse.
- `burst_read`  out  1  burst read request; held for all 4 beats.
- `burst_write`  out  1  burst write request; held for all 4 beats.
- `burst_address`  out  32  latched line address with [4:0] = 0; constant across the burst.
- `burst_wdata`  out  64  current write beat.
- `burst_rdata`  in  64  current read beat; valid when `burst_resp` is high.
- `burst_resp`  in  1  memory accepted or delivered one beat this cycle.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE
  - If `line_read` is high: latch `{line_address[31:5],5'b0}`, clear the beat counter, go to READ.
  - Else if `line_write` is high: latch the address and all 256 bits of `line_wdata`, clear the counter, go to WRITE.
  - Read wins if both are high. Both high together is illegal for the cache, but this priority is required.
- READ
  - `burst_read` = 1.
  - On each `burst_resp`: store `burst_rdata` into line bits [64k+63:64k], where k is the 2-bit counter, then increment k.
  - On the resp with k = 3: go to DONE.
- WRITE
  - `burst_write` = 1 and `burst_wdata` = wbuf[64k+63:64k].
  - On each `burst_resp`: increment k.
  - On the resp with k = 3: go to DONE.
- DONE
  - `line_resp` = 1 for exactly one cycle, then go to IDLE.
  - Requests are not sampled in DONE. The cache drops its request in the cycle after `line_resp`.
- `line_rdata` is a registered buffer. It holds the last completed read line and changes only during READ beats. A write does not alter it.
- `burst_resp` is ignored in IDLE and DONE.
- The counter wraps from 3 to 0 only at the DONE transition; no fifth beat is issued.

## Timing
- Reset (async, immediate) returns to IDLE and forces:
  - `line_resp`, `burst_read`, `burst_write` to 0;
  - `burst_address`, `burst_wdata`, `line_rdata` to 0;
  - the counter and the write buffer to 0.
- Reset mid-burst abandons the burst. `burst_read` and `burst_write` drop in the same cycle `rst` rises, and no `line_resp` is issued.
- Latency: request seen in IDLE at cycle 0; `burst_read`/`burst_write` is high from cycle 1.
  - With `burst_resp` high on cycles 1–4 (zero-wait memory), `line_resp` is high on cycle 5.
  - Generally, `line_resp` is high one cycle after the 4th `burst_resp`.
- Wait states: `burst_resp` may be low for any number of cycles between beats. Outputs must hold steady meanwhile: `burst_read`/`burst_write`, `burst_address`, and `burst_wdata` are unchanged and k does not advance.
- All outputs are registered-state decodes. There is no combinational path from `burst_resp` to `line_resp`.
- Back-to-back: a new request is accepted in the IDLE cycle after DONE, so the minimum request-to-request spacing is 6 cycles.

## Test plan
- Read, zero-wait: `line_read`, address 0x0000_1234.
  - Memory returns beats 0x0..0 / 0x1..1 / 0x2..2 / 0x3..3 on cycles 1–4.
  - Expect `burst_address` = 0x0000_1220, `line_resp` on cycle 5.
  - Expect `line_rdata` = {64'h3..3, 64'h2..2, 64'h1..1, 64'h0..0}.
- Write, wait states: `line_write` with `line_wdata` = {D3,D2,D1,D0}, 2 idle cycles before each resp.
  - Expect `burst_wdata` to show D0, D1, D2, D3 in order, each held through its waits.
  - Expect exactly 4 accepted beats and one `line_resp` pulse.
- Simultaneous `line_read` and `line_write` in IDLE: expect a read burst (`burst_write` stays 0) and `line_rdata` updated.
- Reset after beat 2 of a read: expect `burst_read` to fall immediately, all outputs 0, no `line_resp`, and the next request to start from beat 0.
- Back-to-back read then write: expect no overlap of `burst_read`/`burst_write`, and `line_rdata` to retain the read line after the write completes.
- Stray `burst_resp` pulses in IDLE and DONE: expect no state change, no counter advance, and no extra `line_resp`.

Source files
------------

// File: rtl/cacheline_adapter.sv
// Purpose : turns one 256-bit cache line read/write into a 4-beat 64-bit memory burst.
// Latency : request seen in IDLE at cycle 0, burst from cycle 1, line_resp one cycle after the 4th burst_resp.
// Backpres: memory stalls by holding burst_resp low; all burst outputs and the beat counter hold meanwhile.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   line_read/line_write          cache-side request, held until line_resp
//   line_address, line_wdata      request address (bits [4:0] ignored) and write line
//   line_rdata, line_resp         assembled read line and one-cycle completion pulse
//   burst_read/burst_write        memory-side burst request, held for all 4 beats
//   burst_address, burst_wdata    line-aligned burst address and current write beat
//   burst_rdata, burst_resp       current read beat and per-beat handshake from memory
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [31:0]  line_address,
  input  logic [255:0] line_wdata,
  output logic [255:0] line_rdata,
  output logic         line_resp,
  output logic         burst_read,
  output logic         burst_write,
  output logic [31:0]  burst_address,
  output logic [63:0]  burst_wdata,
  input  logic [63:0]  burst_rdata,
  input  logic         burst_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [1:0]     beat;     // index of the 64-bit beat currently on the bus
  logic [31:0]    addr;
  logic [255:0]   wbuf;
  logic [255:0]   rbuf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= 2'd0;
      addr  <= 32'd0;
      wbuf  <= 256'd0;
      rbuf  <= 256'd0;
    end else begin
      case (state)
        IDLE: begin
          // Read takes priority if the cache ever raises both.
          if (line_read) begin
            addr  <= {line_address[31:5], 5'b0};
            beat  <= 2'd0;
            state <= READ;
          end else if (line_write) begin
            addr  <= {line_address[31:5], 5'b0};
            wbuf  <= line_wdata;
            beat  <= 2'd0;
            state <= WRITE;
          end
        end
        READ: begin
          if (burst_resp) begin
            rbuf[{beat, 6'd0} +: 64] <= burst_rdata;
            // beat wraps 3->0 naturally on the last beat, just as we leave READ
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              state <= DONE;
            end
          end
        end
        WRITE: begin
          if (burst_resp) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // Requests are deliberately not sampled here; the cache is still
          // holding the request it just got a response for.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pure decodes of registered state: nothing from burst_resp reaches an
  // output combinationally, and reset clears every output immediately.
  assign burst_read    = (state == READ);
  assign burst_write   = (state == WRITE);
  assign line_resp     = (state == DONE);
  assign burst_address = addr;
  assign burst_wdata   = wbuf[{beat, 6'd0} +: 64];
  assign line_rdata    = rbuf;

endmodule

// File: tb/tb_cacheline_adapter.sv
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int total = 0;
  int bad   = 0;
  int resp_cnt = 0;
  int beat_cnt = 0;

  cacheline_adapter dut (
    .clk           (clk),
    .rst           (rst),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_address  (line_address),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_address (burst_address),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count completion pulses and accepted beats, sampled mid-cycle.
  always @(negedge clk) begin
    if (line_resp) resp_cnt++;
    if (burst_resp && (burst_read || burst_write)) beat_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait read; returns in the IDLE cycle right after DONE with requests dropped.
  // stray keeps burst_resp high through DONE and the following IDLE cycle.
  task automatic run_read(input string tag, input logic [31:0] a, input logic [31:0] exp_addr,
                          input logic [255:0] ln, input logic also_write, input logic stray);
    line_read    = 1'b1;
    line_write   = also_write;
    line_address = a;
    tick;
    chk({tag, " addr"},  256'(burst_address), 256'(exp_addr));
    chk({tag, " bread"}, 256'(burst_read), 256'(1'b1));
    chk({tag, " bwrite"}, 256'(burst_write), 256'(1'b0));
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = ln[64*i +: 64];
      chk({tag, " resp_early"}, 256'(line_resp), 256'(1'b0));
      chk({tag, " bwrite_beat"}, 256'(burst_write), 256'(1'b0));
      tick;
    end
    burst_resp = stray;
    chk({tag, " resp"},  256'(line_resp), 256'(1'b1));
    chk({tag, " rdata"}, line_rdata, ln);
    chk({tag, " bread_done"}, 256'(burst_read), 256'(1'b0));
    tick;
    line_read  = 1'b0;
    line_write = 1'b0;
    chk({tag, " resp_once"}, 256'(line_resp), 256'(1'b0));
  endtask

  logic [63:0]  d [4];
  logic [255:0] line_a;
  logic [255:0] line_b;
  logic [255:0] line_c;
  logic [255:0] line_d;
  logic [255:0] line_e;
  int           rc0;
  int           bc0;

  initial begin
    d[0] = 64'h0123_4567_89AB_CDEF;
    d[1] = 64'hFEDC_BA98_7654_3210;
    d[2] = 64'hDEAD_BEEF_CAFE_F00D;
    d[3] = 64'h0F1E_2D3C_4B5A_6978;
    line_a = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
              64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
    line_b = {64'hE3E3_E3E3_0000_0003, 64'hE2E2_E2E2_0000_0002,
              64'hE1E1_E1E1_0000_0001, 64'hE0E0_E0E0_0000_0000};
    line_c = {64'hF3F3_0000_0000_F3F3, 64'hF2F2_0000_0000_F2F2,
              64'hF1F1_0000_0000_F1F1, 64'hF0F0_0000_0000_F0F0};
    line_d = {64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5,
              64'h0102_0304_0506_0708, 64'h1020_3040_5060_7080};
    line_e = {64'h7777_0000_0000_0003, 64'h6666_0000_0000_0002,
              64'h5555_0000_0000_0001, 64'h4444_0000_0000_0000};

    rst          = 1'b1;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = 32'd0;
    line_wdata   = 256'd0;
    burst_rdata  = 64'd0;
    burst_resp   = 1'b0;
    tick;
    tick;
    chk("rst bread",  256'(burst_read), 256'(1'b0));
    chk("rst bwrite", 256'(burst_write), 256'(1'b0));
    chk("rst resp",   256'(line_resp), 256'(1'b0));
    chk("rst addr",   256'(burst_address), 256'(32'h0));
    chk("rst wdata",  256'(burst_wdata), 256'(64'h0));
    chk("rst rdata",  line_rdata, 256'h0);
    rst = 1'b0;
    tick;

    // Read, zero-wait memory; line_resp expected on cycle 5.
    rc0 = resp_cnt;
    run_read("rd0", 32'h0000_1234, 32'h0000_1220, line_a, 1'b0, 1'b0);
    tick;
    chk("rd0 idle", 256'(burst_read), 256'(1'b0));
    chk("rd0 npulse", 256'(resp_cnt - rc0), 256'(1));

    // Write with two wait cycles before every beat.
    rc0 = resp_cnt;
    bc0 = beat_cnt;
    line_write   = 1'b1;
    line_address = 32'h8000_001F;
    line_wdata   = {d[3], d[2], d[1], d[0]};
    tick;
    chk("wr addr",  256'(burst_address), 256'(32'h8000_0000));
    chk("wr bread", 256'(burst_read), 256'(1'b0));
    for (int j = 0; j < 4; j++) begin
      for (int w = 0; w < 2; w++) begin
        burst_resp = 1'b0;
        chk("wr wdata_wait", 256'(burst_wdata), 256'(d[j]));
        chk("wr bwrite_wait", 256'(burst_write), 256'(1'b1));
        chk("wr resp_wait", 256'(line_resp), 256'(1'b0));
        tick;
      end
      burst_resp = 1'b1;
      chk("wr wdata_beat", 256'(burst_wdata), 256'(d[j]));
      tick;
    end
    burst_resp = 1'b0;
    chk("wr resp",   256'(line_resp), 256'(1'b1));
    chk("wr bwrite_done", 256'(burst_write), 256'(1'b0));
    chk("wr rdata_kept", line_rdata, line_a);
    tick;
    line_write = 1'b0;
    line_wdata = 256'd0;
    tick;
    chk("wr nbeats",  256'(beat_cnt - bc0), 256'(4));
    chk("wr npulse",  256'(resp_cnt - rc0), 256'(1));

    // Read and write raised together: read must win.
    run_read("both", 32'h0000_0040, 32'h0000_0040, line_b, 1'b1, 1'b0);
    tick;

    // Reset after two beats of a read.
    rc0 = resp_cnt;
    line_read    = 1'b1;
    line_address = 32'h0000_0100;
    tick;
    burst_resp  = 1'b1;
    burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick;
    burst_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
    tick;
    burst_resp = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid bread",  256'(burst_read), 256'(1'b0));
    chk("rstmid bwrite", 256'(burst_write), 256'(1'b0));
    chk("rstmid resp",   256'(line_resp), 256'(1'b0));
    chk("rstmid addr",   256'(burst_address), 256'(32'h0));
    chk("rstmid wdata",  256'(burst_wdata), 256'(64'h0));
    chk("rstmid rdata",  line_rdata, 256'h0);
    line_read = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("rstmid npulse", 256'(resp_cnt - rc0), 256'(0));
    // Next read with one wait before the first beat must fill from beat 0.
    line_read    = 1'b1;
    line_address = 32'h0000_0200;
    tick;
    chk("post bread", 256'(burst_read), 256'(1'b1));
    burst_resp = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = line_c[64*i +: 64];
      tick;
    end
    burst_resp = 1'b0;
    chk("post resp",  256'(line_resp), 256'(1'b1));
    chk("post rdata", line_rdata, line_c);
    tick;
    line_read = 1'b0;
    tick;

    // Back-to-back read then write: write accepted in the IDLE cycle after DONE.
    run_read("b2b", 32'h0000_0300, 32'h0000_0300, line_d, 1'b0, 1'b0);
    line_write   = 1'b1;
    line_address = 32'h0000_0420;
    line_wdata   = {d[0], d[1], d[2], d[3]};
    tick;
    chk("b2b bwrite", 256'(burst_write), 256'(1'b1));
    chk("b2b bread",  256'(burst_read), 256'(1'b0));
    for (int j = 0; j < 4; j++) begin
      burst_resp = 1'b1;
      chk("b2b wdata", 256'(burst_wdata), 256'(d[3-j]));
      chk("b2b overlap", 256'(burst_read), 256'(1'b0));
      tick;
    end
    burst_resp = 1'b0;
    chk("b2b resp",  256'(line_resp), 256'(1'b1));
    chk("b2b rdata_kept", line_rdata, line_d);
    tick;
    line_write = 1'b0;
    tick;

    // Stray burst_resp in IDLE, then through DONE.
    rc0 = resp_cnt;
    for (int s = 0; s < 3; s++) begin
      burst_resp  = 1'b1;
      burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick;
      chk("stray idle bread",  256'(burst_read), 256'(1'b0));
      chk("stray idle bwrite", 256'(burst_write), 256'(1'b0));
      chk("stray idle resp",   256'(line_resp), 256'(1'b0));
    end
    chk("stray idle rdata", line_rdata, line_d);
    run_read("stray", 32'h0000_05E0, 32'h0000_05E0, line_e, 1'b0, 1'b1);
    burst_resp = 1'b0;
    tick;
    chk("stray idle2", 256'(burst_read), 256'(1'b0));
    chk("stray resp_after", 256'(line_resp), 256'(1'b0));
    chk("stray npulse", 256'(resp_cnt - rc0), 256'(1));
    chk("stray rdata", line_rdata, line_e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
